// File: rtl/dpram_be_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dpram_be_pipe_pkg
// Shared definitions for the byte-enabled, pipelined dual-port RAM:
//   - state_t     : clear-engine FSM encoding (ST_IDLE, ST_CLEAR)
//   - nb_of()     : number of byte lanes in a word
//   - width_ok()  : word width is a whole number of byte lanes
//   - lat_ok()    : read latency is one of the supported depths
// -----------------------------------------------------------------------------
package dpram_be_pipe_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int nb_of(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit width_ok(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

    function automatic bit lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage

// File: rtl/dpram_be_core.sv
// -----------------------------------------------------------------------------
// dpram_be_core
// Storage array with one byte-enabled write port and one registered read port.
// Read data is the pre-write contents when both ports hit the same address on
// the same edge; any forwarding is done by the caller.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, be     : write strobe and per-lane enables
//   waddr      : write address
//   wdata      : write data
//   re, raddr  : read strobe and address
//   rdata      : registered read data, updated only on re
// -----------------------------------------------------------------------------
module dpram_be_core
    import dpram_be_pipe_pkg::*;
#(
    parameter int  ADDR_WIDTH = 12,
    parameter int  DATA_WIDTH = 32,
    parameter int  BYTE_WIDTH = 8,
    localparam int NB         = nb_of(DATA_WIDTH, BYTE_WIDTH),
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [NB-1:0]         be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; it is
    // initialised by the clear engine instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // NOTE: non-blocking assignment here means a same-edge read sees the
    // old word, which is the read-before-write behaviour the top relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dpram_be_pipe.sv
// -----------------------------------------------------------------------------
// dpram_be_pipe
// Simple dual-port RAM for FFT buffering with byte-lane writes, a 1- or 2-cycle
// read pipeline with a valid strobe, optional write-to-read forwarding on an
// address collision, and a clear engine that zeroes every word.
//   clk, rst_n  : clock, async active-low reset
//   clr         : pulse to start a clear sweep (ignored while one runs)
//   busy        : clear sweep in progress; user reads/writes are dropped
//   wen, wbe    : write request and byte-lane enables
//   waddr, din  : write address and data
//   ren, raddr  : read request and address
//   dout        : read data, held between completed reads
//   rvalid      : one-cycle strobe per completed read, RD_LAT cycles after ren
// -----------------------------------------------------------------------------
module dpram_be_pipe
    import dpram_be_pipe_pkg::*;
#(
    parameter int  ADDR_WIDTH = 12,
    parameter int  DATA_WIDTH = 32,
    parameter int  BYTE_WIDTH = 8,
    parameter int  RD_LAT     = 1,
    parameter bit  BYPASS     = 1'b1,
    parameter bit  INIT_CLR   = 1'b1,
    localparam int NB         = nb_of(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  wen,
    input  logic [NB-1:0]         wbe,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rvalid
);

    if (!width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("dpram_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (!lat_ok(RD_LAT)) begin : g_bad_lat
        $error("dpram_be_pipe: RD_LAT must be 1 or 2");
    end

    localparam state_t RST_STATE = INIT_CLR ? ST_CLEAR : ST_IDLE;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  cnt_last;

    assign cnt_last = &cnt;

    // ---------------- clear-engine FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr)      state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt_last) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state == ST_CLEAR) busy = 1'b1;
    end

    // Sweep address; the edge that clears the all-ones address returns it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

    // ---------------- array access ----------------
    // The sweep owns the write port outright; user traffic is dropped while busy.
    logic                  mem_we;
    logic [NB-1:0]         mem_be;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] raw_q;

    assign mem_we    = busy | wen;
    assign mem_be    = busy ? '1 : wbe;
    assign mem_waddr = busy ? cnt : waddr;
    assign mem_wdata = busy ? '0 : din;
    assign rd_acc    = ren & ~busy;

    dpram_be_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (raddr),
        .rdata (raw_q)
    );

    // ---------------- collision forwarding ----------------
    // The core returns the pre-write word, so the colliding write lanes are
    // captured alongside the read and patched in after the array register.
    logic                  hit;
    logic                  hit_q;
    logic [NB-1:0]         wbe_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rd_word;

    assign hit = BYPASS && wen && (waddr == raddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= 1'b0;
            wbe_q   <= '0;
            din_q   <= '0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid1 <= rd_acc;
            if (rd_acc) begin
                hit_q <= hit;
                wbe_q <= wbe;
                din_q <= din;
            end
        end
    end

    always_comb begin
        rd_word = raw_q;
        for (int i = 0; i < NB; i++) begin
            if (hit_q && wbe_q[i]) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // ---------------- latency pipeline ----------------
    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  rvalid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rvalid1;
                if (rvalid1) dout_q <= rd_word;
            end
        end

        assign dout   = dout_q;
        assign rvalid = rvalid_q;
    end else begin : g_lat1
        assign dout   = rd_word;
        assign rvalid = rvalid1;
    end

endmodule

// File: tb/tb_dpram_be_pipe.sv
module tb_dpram_be_pipe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wen;
    logic [3:0]    wbe;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          ren;
    logic [AW-1:0] raddr;

    logic          busy_a, rvalid_a;
    logic [DW-1:0] dout_a;
    logic          busy_b, rvalid_b;
    logic [DW-1:0] dout_b;
    logic          busy_c, rvalid_c;
    logic [DW-1:0] dout_c;

    int n_tests;
    int n_fail;

    // a: RD_LAT=1 with forwarding; b: RD_LAT=2 without; c: no initial clear
    dpram_be_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                    .RD_LAT(1), .BYPASS(1'b1), .INIT_CLR(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
        .wen(wen), .wbe(wbe), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout_a), .rvalid(rvalid_a));

    dpram_be_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                    .RD_LAT(2), .BYPASS(1'b0), .INIT_CLR(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
        .wen(wen), .wbe(wbe), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout_b), .rvalid(rvalid_b));

    dpram_be_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                    .RD_LAT(1), .BYPASS(1'b1), .INIT_CLR(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_c),
        .wen(wen), .wbe(wbe), .waddr(waddr), .din(din),
        .ren(ren), .raddr(raddr), .dout(dout_c), .rvalid(rvalid_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_busy;
    int            ref_cnt;
    bit            exp_rv_a, exp_rv_b;
    logic [DW-1:0] exp_do_a, exp_do_b;
    bit            pend_v;
    logic [DW-1:0] pend_d;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [3:0]    be);
        logic [DW-1:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_reset();
        ref_busy = 1'b1;
        ref_cnt  = 0;
        exp_rv_a = 1'b0;
        exp_rv_b = 1'b0;
        exp_do_a = '0;
        exp_do_b = '0;
        pend_v   = 1'b0;
        pend_d   = '0;
    endtask

    // One rising edge: evaluate reads on the pre-edge array, then update it.
    task automatic model_edge();
        bit            rd;
        logic [DW-1:0] old_w;
        logic [DW-1:0] fwd_w;
        rd    = ren && !ref_busy;
        old_w = ref_mem[raddr];
        fwd_w = (wen && waddr == raddr) ? merge(old_w, din, wbe) : old_w;
        exp_rv_b = pend_v;
        if (pend_v) exp_do_b = pend_d;
        pend_v = rd;
        pend_d = old_w;
        exp_rv_a = rd;
        if (rd) exp_do_a = fwd_w;
        if (ref_busy) begin
            ref_mem[ref_cnt] = '0;
            ref_cnt++;
            if (ref_cnt == DEPTH) begin
                ref_busy = 1'b0;
                ref_cnt  = 0;
            end
        end else begin
            if (wen) ref_mem[waddr] = merge(ref_mem[waddr], din, wbe);
            if (clr) ref_busy = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit w, input logic [3:0] be, input logic [AW-1:0] wa,
                         input logic [DW-1:0] d, input bit r, input logic [AW-1:0] ra);
        wen   = w;
        wbe   = be;
        waddr = wa;
        din   = d;
        ren   = r;
        raddr = ra;
    endtask

    task automatic idle_inputs();
        clr = 1'b0;
        drive(1'b0, 4'h0, '0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Runs a clear sweep to completion, returning how many edges busy stayed high.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (dout_a !== '0)    begin n_fail++; $display("FAIL reset dout_a: got %h expected 0", dout_a); end
        n_tests++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL reset rvalid_a: got %b expected 0", rvalid_a); end
        n_tests++; if (dout_b !== '0)    begin n_fail++; $display("FAIL reset dout_b: got %h expected 0", dout_b); end
        n_tests++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL reset rvalid_b: got %b expected 0", rvalid_b); end
        n_tests++; if (busy_a !== 1'b1)  begin n_fail++; $display("FAIL reset busy_a: got %b expected 1", busy_a); end
        n_tests++; if (busy_c !== 1'b0)  begin n_fail++; $display("FAIL reset busy_c: got %b expected 0", busy_c); end
        rst_n = 1'b1;
    endtask

    task automatic test_init_clear();
        int n;
        wait_sweep(n);
        n_tests++; if (n != 16) begin n_fail++; $display("FAIL init_clear busy_cycles: got %0d expected 16", n); end
        n_tests++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL init_clear busy_c: got %b expected 0", busy_c); end
        for (int i = 0; i <= DEPTH + 1; i++) begin
            drive(1'b0, 4'h0, '0, '0, i < DEPTH, AW'(i));
            tick();
            n_tests++; if (rvalid_a !== exp_rv_a) begin n_fail++; $display("FAIL init_read rvalid_a[%0d]: got %b expected %b", i, rvalid_a, exp_rv_a); end
            n_tests++; if (dout_a !== exp_do_a)   begin n_fail++; $display("FAIL init_read dout_a[%0d]: got %h expected %h", i, dout_a, exp_do_a); end
            n_tests++; if (rvalid_b !== exp_rv_b) begin n_fail++; $display("FAIL init_read rvalid_b[%0d]: got %b expected %b", i, rvalid_b, exp_rv_b); end
            n_tests++; if (dout_b !== exp_do_b)   begin n_fail++; $display("FAIL init_read dout_b[%0d]: got %h expected %h", i, dout_b, exp_do_b); end
        end
        idle_inputs();
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 1'b0, '0); tick();
        drive(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0); tick();
        drive(1'b0, 4'b0000, 4'd0, 32'h0,        1'b1, 4'd3); tick();
        idle_inputs();
        n_tests++; if (rvalid_a !== 1'b1 || dout_a !== 32'hAA22CC44) begin n_fail++; $display("FAIL byte_enable dout_a: got %b/%h expected 1/aa22cc44", rvalid_a, dout_a); end
        tick();
        n_tests++; if (rvalid_b !== 1'b1 || dout_b !== 32'hAA22CC44) begin n_fail++; $display("FAIL byte_enable dout_b: got %b/%h expected 1/aa22cc44", rvalid_b, dout_b); end
        n_tests++; if (rvalid_a !== 1'b0 || dout_a !== 32'hAA22CC44) begin n_fail++; $display("FAIL byte_enable hold_a: got %b/%h expected 0/aa22cc44", rvalid_a, dout_a); end
    endtask

    task automatic test_collision();
        drive(1'b1, 4'b0011, 4'd5, 32'h12345678, 1'b1, 4'd5); tick();
        idle_inputs();
        n_tests++; if (rvalid_a !== 1'b1 || dout_a !== 32'h00005678) begin n_fail++; $display("FAIL collision bypass_a: got %b/%h expected 1/00005678", rvalid_a, dout_a); end
        tick();
        n_tests++; if (rvalid_b !== 1'b1 || dout_b !== 32'h00000000) begin n_fail++; $display("FAIL collision old_b: got %b/%h expected 1/00000000", rvalid_b, dout_b); end
        drive(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd5); tick();
        idle_inputs();
        n_tests++; if (rvalid_a !== 1'b1 || dout_a !== 32'h00005678) begin n_fail++; $display("FAIL collision reread_a: got %b/%h expected 1/00005678", rvalid_a, dout_a); end
        tick();
        n_tests++; if (rvalid_b !== 1'b1 || dout_b !== 32'h00005678) begin n_fail++; $display("FAIL collision reread_b: got %b/%h expected 1/00005678", rvalid_b, dout_b); end
    endtask

    task automatic test_back_to_back();
        bit            want_a, want_b;
        logic [DW-1:0] val_a, val_b;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'hF, AW'(i), DW'(10 + i), 1'b0, '0);
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 4'h0, '0, '0, j < 4, AW'(j));
            tick();
            want_a = (j < 4);
            want_b = (j >= 1 && j <= 4);
            val_a  = DW'(10 + (j < 4 ? j : 3));
            val_b  = DW'(j == 0 ? 32'h00005678 : 10 + (j <= 4 ? j - 1 : 3));
            n_tests++; if (rvalid_a !== want_a) begin n_fail++; $display("FAIL b2b rvalid_a[%0d]: got %b expected %b", j, rvalid_a, want_a); end
            n_tests++; if (dout_a !== val_a)    begin n_fail++; $display("FAIL b2b dout_a[%0d]: got %h expected %h", j, dout_a, val_a); end
            n_tests++; if (rvalid_b !== want_b) begin n_fail++; $display("FAIL b2b rvalid_b[%0d]: got %b expected %b", j, rvalid_b, want_b); end
            n_tests++; if (dout_b !== val_b)    begin n_fail++; $display("FAIL b2b dout_b[%0d]: got %h expected %h", j, dout_b, val_b); end
        end
        idle_inputs();
    endtask

    task automatic test_clear_request();
        int n;
        drive(1'b1, 4'hF, 4'd9, 32'h0000DEAD, 1'b0, '0); tick();
        idle_inputs();
        clr = 1'b1; tick(); clr = 1'b0;
        n = 0;
        while (busy_a && n < 40) begin
            drive(1'b1, 4'hF, 4'd2, 32'h0000BEEF, 1'b1, AW'($urandom_range(0, 15)));
            clr = (n == 3);
            tick();
            n++;
            if (n > 1) begin
                n_tests++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL clear busy_rvalid_a[%0d]: got %b expected 0", n, rvalid_a); end
            end
            if (n > 2) begin
                n_tests++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL clear busy_rvalid_b[%0d]: got %b expected 0", n, rvalid_b); end
            end
        end
        idle_inputs();
        n_tests++; if (n != 16) begin n_fail++; $display("FAIL clear busy_cycles: got %0d expected 16", n); end
        drive(1'b0, 4'h0, '0, '0, 1'b1, 4'd9); tick();
        n_tests++; if (rvalid_a !== 1'b1 || dout_a !== '0) begin n_fail++; $display("FAIL clear addr9: got %b/%h expected 1/00000000", rvalid_a, dout_a); end
        drive(1'b0, 4'h0, '0, '0, 1'b1, 4'd2); tick();
        idle_inputs();
        n_tests++; if (rvalid_a !== 1'b1 || dout_a !== '0) begin n_fail++; $display("FAIL clear addr2: got %b/%h expected 1/00000000", rvalid_a, dout_a); end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        drive(1'b1, 4'hF, 4'd1, 32'hCAFEF00D, 1'b0, '0); tick();
        drive(1'b0, 4'h0, '0, '0, 1'b1, 4'd1); tick();
        idle_inputs(); tick();
        n_tests++; if (dout_a !== 32'hCAFEF00D || dout_b !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst preload: got %h/%h expected cafef00d", dout_a, dout_b); end
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (7) tick();
        n_tests++; if (ref_cnt != 7 || busy_a !== 1'b1) begin n_fail++; $display("FAIL midrst position: got cnt %0d busy %b expected 7/1", ref_cnt, busy_a); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (dout_a !== '0 || rvalid_a !== 1'b0) begin n_fail++; $display("FAIL midrst async_a: got %h/%b expected 0/0", dout_a, rvalid_a); end
        n_tests++; if (dout_b !== '0 || rvalid_b !== 1'b0) begin n_fail++; $display("FAIL midrst async_b: got %h/%b expected 0/0", dout_b, rvalid_b); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sweep(n);
        n_tests++; if (n != 16) begin n_fail++; $display("FAIL midrst busy_cycles: got %0d expected 16", n); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 4'h0, '0, '0, 1'b1, AW'(i));
            tick();
            n_tests++; if (rvalid_a !== 1'b1 || dout_a !== '0) begin n_fail++; $display("FAIL midrst read[%0d]: got %b/%h expected 1/00000000", i, rvalid_a, dout_a); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 1) == 1, 4'($urandom), AW'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, AW'($urandom));
            if ($urandom_range(0, 3) == 0) raddr = waddr;
            clr = ($urandom_range(0, 79) == 0);
            tick();
            n_tests++; if (busy_a !== ref_busy)   begin n_fail++; $display("FAIL random busy_a[%0d]: got %b expected %b", k, busy_a, ref_busy); end
            n_tests++; if (rvalid_a !== exp_rv_a) begin n_fail++; $display("FAIL random rvalid_a[%0d]: got %b expected %b", k, rvalid_a, exp_rv_a); end
            n_tests++; if (dout_a !== exp_do_a)   begin n_fail++; $display("FAIL random dout_a[%0d]: got %h expected %h", k, dout_a, exp_do_a); end
            n_tests++; if (rvalid_b !== exp_rv_b) begin n_fail++; $display("FAIL random rvalid_b[%0d]: got %b expected %b", k, rvalid_b, exp_rv_b); end
            n_tests++; if (dout_b !== exp_do_b)   begin n_fail++; $display("FAIL random dout_b[%0d]: got %h expected %h", k, dout_b, exp_do_b); end
        end
        idle_inputs();
        wait_sweep(n);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL random drain busy_a: got %b expected 0", busy_a); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        test_reset();
        test_init_clear();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_clear_request();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
